// File: rtl/rc_receiver_multi_pkg.sv
// rtl/rc_receiver_multi_pkg.sv - shared RC receiver constants, default failsafe values and channel FSM states
package rc_receiver_multi_pkg;

    localparam int REC_VAL_BIT_WIDTH   = 8;
    localparam int RC_DEFAULT_CHANNELS = 7;

    localparam int RC_PULSE_MIN_US     = 1000;
    localparam int RC_PULSE_MAX_US     = 2000;
    localparam int RC_PULSE_SHIFT      = 2;
    localparam int RC_PULSE_GLITCH_US  = 500;
    localparam int RC_PULSE_ABS_MAX_US = 2500;
    localparam int RC_PULSE_TIMEOUT_US = 25000;

    // Channel 0 is throttle and fails safe to zero; the sticks fail safe to centre.
    localparam logic [RC_DEFAULT_CHANNELS*REC_VAL_BIT_WIDTH-1:0] RC_FAILSAFE_DEFAULT =
        {{6{8'd125}}, 8'd0};

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } rc_state_e;

endpackage

// File: rtl/rc_channel_capture.sv
// rtl/rc_channel_capture.sv - one PWM channel: sync, width FSM, scaler, timeout failsafe, optional median (RC_RECEIVER_MEDIAN3_FILTER_EN)
module rc_channel_capture
    import rc_receiver_multi_pkg::*;
#(
    parameter int                   VAL_WIDTH        = REC_VAL_BIT_WIDTH,
    parameter int                   PULSE_MIN_US     = RC_PULSE_MIN_US,
    parameter int                   PULSE_MAX_US     = RC_PULSE_MAX_US,
    parameter int                   SCALE_SHIFT      = RC_PULSE_SHIFT,
    parameter int                   GLITCH_US        = RC_PULSE_GLITCH_US,
    parameter int                   PULSE_ABS_MAX_US = RC_PULSE_ABS_MAX_US,
    parameter int                   TIMEOUT_US       = RC_PULSE_TIMEOUT_US,
    parameter logic [VAL_WIDTH-1:0] FAILSAFE_VAL     = '0
) (
    input  logic                 us_clk,
    input  logic                 reset,
    input  logic                 pwm_in,
    output logic [VAL_WIDTH-1:0] val_out,
    output logic                 val_strobe,
    output logic                 channel_lost
);

    localparam int WCNT_W     = $clog2(PULSE_ABS_MAX_US + 2);
    localparam int TO_W       = $clog2(TIMEOUT_US + 1);
    localparam int FULL_SCALE = (PULSE_MAX_US - PULSE_MIN_US) >> SCALE_SHIFT;

    localparam logic [WCNT_W-1:0] CNT_SAT  = WCNT_W'(PULSE_ABS_MAX_US + 1);
    localparam logic [WCNT_W-1:0] GLITCH_W = WCNT_W'(GLITCH_US);
    localparam logic [WCNT_W-1:0] MIN_W    = WCNT_W'(PULSE_MIN_US);
    localparam logic [WCNT_W-1:0] MAX_W    = WCNT_W'(PULSE_MAX_US);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_US);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_US - 1);

    logic                 sync_1, sync_2, sync_prev;
    logic                 rise, fall;
    rc_state_e            state, state_nxt;
    logic [WCNT_W-1:0]    width_cnt, width_cnt_nxt;
    logic                 pulse_valid;
    logic [VAL_WIDTH-1:0] scaled;
    logic [TO_W-1:0]      to_cnt;
    logic                 ev_valid;
    logic [VAL_WIDTH-1:0] ev_val;

    // Two-flop synchronizer plus a history flop for edge detection. They reset
    // high so a line already high at reset release is treated as a pulse in
    // progress and held off by WAIT_LOW rather than measured.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= pwm_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_prev;
    assign fall = ~sync_2 & sync_prev;

    // FSM and width counter state register.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LOW;
            width_cnt <= '0;
        end else begin
            state     <= state_nxt;
            width_cnt <= width_cnt_nxt;
        end
    end

    // Next-state logic: the counter restarts at 1 on the rise so that at the
    // falling edge it holds exactly the number of high cycles.
    always_comb begin
        state_nxt     = state;
        width_cnt_nxt = width_cnt;
        pulse_valid   = 1'b0;
        unique case (state)
            WAIT_LOW: begin
                if (!sync_2) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    width_cnt_nxt = WCNT_W'(1);
                    state_nxt     = MEASURE;
                end
            end
            MEASURE: begin
                if (width_cnt == CNT_SAT) begin
                    state_nxt = WAIT_LOW;
                end else if (fall) begin
                    state_nxt   = WAIT_RISE;
                    pulse_valid = (width_cnt >= GLITCH_W);
                end else begin
                    width_cnt_nxt = width_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOW;
            end
        endcase
    end

    // Map the measured width onto 0..FULL_SCALE, clamping both ends.
    always_comb begin
        scaled = '0;
        if (width_cnt < MIN_W) begin
            scaled = '0;
        end else if (width_cnt > MAX_W) begin
            scaled = VAL_WIDTH'(FULL_SCALE);
        end else begin
            scaled = VAL_WIDTH'((width_cnt - MIN_W) >> SCALE_SHIFT);
        end
    end

`ifdef RC_RECEIVER_MEDIAN3_FILTER_EN
    logic                 valid_q;
    logic [VAL_WIDTH-1:0] sample_q;
    logic [VAL_WIDTH-1:0] hist_0, hist_1;

    function automatic logic [VAL_WIDTH-1:0] med3(input logic [VAL_WIDTH-1:0] a,
                                                  input logic [VAL_WIDTH-1:0] b,
                                                  input logic [VAL_WIDTH-1:0] c);
        if ((a <= b && b <= c) || (c <= b && b <= a)) begin
            return b;
        end else if ((b <= a && a <= c) || (c <= a && a <= b)) begin
            return a;
        end
        return c;
    endfunction

    // Extra pipeline stage so the median sees the new sample and two previous ones.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            valid_q  <= pulse_valid;
            sample_q <= scaled;
        end
    end

    // Sample history; after reset or loss the whole window is primed with the
    // first new sample so the first output equals that sample.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            hist_0 <= '0;
            hist_1 <= '0;
        end else if (valid_q) begin
            hist_0 <= sample_q;
            hist_1 <= channel_lost ? sample_q : hist_0;
        end
    end

    assign ev_valid = valid_q;
    assign ev_val   = channel_lost ? sample_q : med3(sample_q, hist_0, hist_1);
`else
    assign ev_valid = pulse_valid;
    assign ev_val   = scaled;
`endif

    // Output register and signal-loss timer; a valid pulse always beats expiry.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            val_out      <= FAILSAFE_VAL;
            val_strobe   <= 1'b0;
            channel_lost <= 1'b1;
            to_cnt       <= '0;
        end else begin
            val_strobe <= ev_valid;
            if (ev_valid) begin
                val_out      <= ev_val;
                channel_lost <= 1'b0;
                to_cnt       <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    channel_lost <= 1'b1;
                    val_out      <= FAILSAFE_VAL;
                end
            end
        end
    end

endmodule

// File: rtl/rc_receiver_multi.sv
// rtl/rc_receiver_multi.sv - N-channel RC PWM receiver front end with failsafe (median option: RC_RECEIVER_MEDIAN3_FILTER_EN)
module rc_receiver_multi
    import rc_receiver_multi_pkg::*;
#(
    parameter int NUM_CHANNELS     = RC_DEFAULT_CHANNELS,
    parameter int VAL_WIDTH        = REC_VAL_BIT_WIDTH,
    parameter int PULSE_MIN_US     = RC_PULSE_MIN_US,
    parameter int PULSE_MAX_US     = RC_PULSE_MAX_US,
    parameter int SCALE_SHIFT      = RC_PULSE_SHIFT,
    parameter int GLITCH_US        = RC_PULSE_GLITCH_US,
    parameter int PULSE_ABS_MAX_US = RC_PULSE_ABS_MAX_US,
    parameter int TIMEOUT_US       = RC_PULSE_TIMEOUT_US,
    parameter logic [NUM_CHANNELS*VAL_WIDTH-1:0] FAILSAFE_VALS = RC_FAILSAFE_DEFAULT
) (
    input  logic                              us_clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           pwm_in,
    output logic [NUM_CHANNELS*VAL_WIDTH-1:0] val_out,
    output logic [NUM_CHANNELS-1:0]           val_strobe,
    output logic [NUM_CHANNELS-1:0]           channel_lost,
    output logic                              all_lost
);

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        rc_channel_capture #(
            .VAL_WIDTH        (VAL_WIDTH),
            .PULSE_MIN_US     (PULSE_MIN_US),
            .PULSE_MAX_US     (PULSE_MAX_US),
            .SCALE_SHIFT      (SCALE_SHIFT),
            .GLITCH_US        (GLITCH_US),
            .PULSE_ABS_MAX_US (PULSE_ABS_MAX_US),
            .TIMEOUT_US       (TIMEOUT_US),
            .FAILSAFE_VAL     (FAILSAFE_VALS[k*VAL_WIDTH +: VAL_WIDTH])
        ) u_capture (
            .us_clk       (us_clk),
            .reset        (reset),
            .pwm_in       (pwm_in[k]),
            .val_out      (val_out[k*VAL_WIDTH +: VAL_WIDTH]),
            .val_strobe   (val_strobe[k]),
            .channel_lost (channel_lost[k])
        );
    end

    assign all_lost = &channel_lost;

endmodule

// File: tb/tb_rc_receiver_multi.sv
// tb/tb_rc_receiver_multi.sv - self-checking bench for rc_receiver_multi against a pulse-level reference model
module tb_rc_receiver_multi;

    localparam int NCH     = 7;
    localparam int VW      = 8;
    localparam int GLITCH  = 500;
    localparam int ABSMAX  = 2500;
    localparam int TIMEOUT = 25000;
`ifdef RC_RECEIVER_MEDIAN3_FILTER_EN
    localparam int LAT = 4;
    localparam bit MED = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit MED = 1'b0;
`endif

    logic              us_clk = 1'b0;
    logic              reset  = 1'b1;
    logic [NCH-1:0]    pwm_in = '0;
    logic [NCH*VW-1:0] val_out;
    logic [NCH-1:0]    val_strobe;
    logic [NCH-1:0]    channel_lost;
    logic              all_lost;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;

    int fs_val [NCH] = '{0, 125, 125, 125, 125, 125, 125};
    int ever   [NCH];
    int last_t [NCH];
    int cur    [NCH];
    int h0     [NCH];
    int h1     [NCH];

    rc_receiver_multi dut (
        .us_clk       (us_clk),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .val_out      (val_out),
        .val_strobe   (val_strobe),
        .channel_lost (channel_lost),
        .all_lost     (all_lost)
    );

    always #5 us_clk = ~us_clk;

    always @(posedge us_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int scale(input int w);
        if (w < 1000) return 0;
        if (w > 2000) return 250;
        return (w - 1000) / 4;
    endfunction

    function automatic int med(input int a, input int b, input int c);
        int mx, mn;
        mx = (a > b) ? a : b;
        mx = (mx > c) ? mx : c;
        mn = (a < b) ? a : b;
        mn = (mn < c) ? mn : c;
        return a + b + c - mx - mn;
    endfunction

    function automatic bit lost_at(input int ch, input int t);
        return (ever[ch] == 0) || ((t - last_t[ch]) >= TIMEOUT);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            ever[k] = 0; last_t[k] = 0; cur[k] = 0; h0[k] = 0; h1[k] = 0;
        end
    endtask

    // Record a valid pulse of width w whose falling edge left the pin when cyc == c.
    task automatic model_valid(input int ch, input int w, input int c);
        int t, s;
        t = c + LAT;
        s = scale(w);
        if (MED) begin
            if (lost_at(ch, t - 1)) begin
                h0[ch] = s; h1[ch] = s; cur[ch] = s;
            end else begin
                cur[ch] = med(s, h0[ch], h1[ch]);
                h1[ch]  = h0[ch];
                h0[ch]  = s;
            end
        end else begin
            cur[ch] = s;
        end
        ever[ch]   = 1;
        last_t[ch] = t;
    endtask

    task automatic check_all(input string tag);
        bit al, l;
        al = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            l  = lost_at(k, cyc);
            al = al & l;
            chk($sformatf("%s lost[%0d]", tag, k), 32'(channel_lost[k]), 32'(l));
            chk($sformatf("%s val[%0d]", tag, k), 32'(val_out[k*VW +: VW]),
                l ? fs_val[k] : cur[k]);
        end
        chk({tag, " all_lost"}, 32'(all_lost), 32'(al));
    endtask

    task automatic run_pulse(input int ch, input int w, input string tag);
        int c, seen_at, n_str;
        bit lost_seen, lost_prev, exp_prev;
        @(negedge us_clk);
        pwm_in[ch] = 1'b1;
        repeat (w) @(negedge us_clk);
        pwm_in[ch] = 1'b0;
        c = cyc;
        seen_at = -1; n_str = 0; lost_seen = 1'b1; lost_prev = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge us_clk);
            if (k == LAT - 1) lost_prev = channel_lost[ch];
            if (val_strobe[ch]) begin
                n_str++;
                if (seen_at < 0) begin
                    seen_at   = k;
                    lost_seen = channel_lost[ch];
                end
            end
        end
        if (w >= GLITCH && w <= ABSMAX) begin
            exp_prev = lost_at(ch, c + LAT - 1);
            chk({tag, " strobe cycle"}, seen_at, LAT);
            chk({tag, " strobe count"}, n_str, 1);
            chk({tag, " lost before strobe"}, 32'(lost_prev), 32'(exp_prev));
            chk({tag, " lost at strobe"}, 32'(lost_seen), 0);
            model_valid(ch, w, c);
        end else begin
            chk({tag, " no strobe"}, n_str, 0);
        end
        check_all(tag);
    endtask

    task automatic run_all(input int w, input string tag);
        int c;
        int seen_at [NCH];
        @(negedge us_clk);
        pwm_in = '1;
        repeat (w) @(negedge us_clk);
        pwm_in = '0;
        c = cyc;
        for (int k = 0; k < NCH; k++) seen_at[k] = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge us_clk);
            for (int j = 0; j < NCH; j++) begin
                if (val_strobe[j] && seen_at[j] < 0) seen_at[j] = k;
            end
        end
        for (int j = 0; j < NCH; j++) begin
            chk($sformatf("%s strobe cycle[%0d]", tag, j), seen_at[j], LAT);
            model_valid(j, w, c);
        end
        check_all(tag);
    endtask

    initial begin
        int bnd [6];
        int c, n_str;
        bnd = '{499, 500, 2500, 2501, 999, 2001};
        model_reset();

        repeat (3) @(negedge us_clk);
        chk("reset strobe", 32'(val_strobe), 0);
        check_all("reset");
        reset = 1'b0;
        repeat (5) @(negedge us_clk);

        run_pulse(2, 1500, "ch2 1500");

        run_pulse(1, 900,  "ch1 900");
        run_pulse(1, 2000, "ch1 2000");
        run_pulse(1, 2300, "ch1 2300");
        run_pulse(1, 2600, "ch1 2600");
        run_pulse(1, 1200, "ch1 1200");

        run_pulse(3, 1600, "ch3 1600");
        run_pulse(3, 300,  "ch3 glitch");

        run_pulse(5, 1000, "ch5 1000");
        run_pulse(5, 2000, "ch5 2000");
        run_pulse(5, 1500, "ch5 1500");

        run_pulse(0, 1800, "ch0 1800");
        while (cyc < last_t[0] + TIMEOUT - 1) @(negedge us_clk);
        chk("timeout edge-1 lost0", 32'(channel_lost[0]), 0);
        @(negedge us_clk);
        chk("timeout lost0", 32'(channel_lost[0]), 1);
        chk("timeout val0", 32'(val_out[0 +: VW]), 0);
        chk("timeout all_lost", 32'(all_lost), 1);
        check_all("timeout");

        run_all(1400, "all 1400");

        for (int i = 0; i < 10; i++) begin
            int ch, w;
            ch = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 2) == 0) w = bnd[$urandom_range(0, 5)];
            else w = $urandom_range(300, 2700);
            run_pulse(ch, w, $sformatf("rand%0d ch%0d w%0d", i, ch, w));
        end

        @(negedge us_clk);
        pwm_in[4] = 1'b1;
        repeat (300) @(negedge us_clk);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("async reset strobe", 32'(val_strobe), 0);
        check_all("async reset");
        repeat (100) @(negedge us_clk);
        reset = 1'b0;
        repeat (400) @(negedge us_clk);
        pwm_in[4] = 1'b0;
        c = cyc;
        n_str = 0;
        repeat (8) begin
            @(negedge us_clk);
            if (|val_strobe) n_str++;
        end
        chk("ch4 pulse across reset no strobe", n_str, 0);
        check_all("ch4 after reset");
        run_pulse(4, 1100, "ch4 1100");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
